aes_enc_iter: RTL and testbench

- Iterative AES-128 encryption engine. Runs AddRoundKey, SubBytes, ShiftRows, MixColumns and the on-the-fly key schedule over 1..NUM_ROUNDS rounds, one round per clock.
- Successor to the combinational round-0/round-1 datapath: parametrised round count, registered state, valid/ready handshake on both sides.
- Sits between the block-input buffer and the ciphertext sink.

---
 rtl/aes_pkg.sv | 60 ++++++
 rtl/aes_round_comb.sv | 47 ++++
 rtl/aes_sbox.sv | 13 +
 rtl/aes_shift_rows.sv | 18 +
 rtl/aes_subbytes.sv | 18 +
 rtl/aes_enc_iter.sv | 154 +++++++++++++++
 tb/tb_aes_enc_iter.sv | 312 +++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared types and constants for the iterative AES-128 engine.
//   state_t   : engine FSM encoding (IDLE, RUN, DONE)
//   AES_BLK_W : block and key width
//   RCON      : round constants, index 1..10 (index 0 unused)
//   SBOX      : forward AES S-box
//   xtime     : GF(2^8) multiply-by-2, polynomial 0x11b
//   sbox      : single byte substitution
//   rcon      : bounded RCON lookup; returns 0 outside 1..10
//   sub_word  : 32-bit SubWord (four S-box lookups)
package aes_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] RCON [0:10] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        return (i <= 4'd10) ? RCON[i] : 8'h00;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// aes_round_comb: one combinational AES round.
//   state      : current state
//   round_key  : key for this round (already expanded)
//   last_round : skip MixColumns (final round)
//   next_state : SubBytes -> ShiftRows -> [MixColumns] -> AddRoundKey
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] state,
    input  logic [AES_BLK_W-1:0] round_key,
    input  logic                 last_round,
    output logic [AES_BLK_W-1:0] next_state
);

    logic [AES_BLK_W-1:0] sb;
    logic [AES_BLK_W-1:0] sr;
    logic [AES_BLK_W-1:0] mc;

    // Column bytes a0..a3 are rows 0..3; matrix rows are {2,3,1,1} rotated.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        {a0, a1, a2, a3} = col;
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    aes_subbytes u_subbytes (
        .din  (state),
        .dout (sb)
    );

    aes_shift_rows u_shift_rows (
        .din  (sb),
        .dout (sr)
    );

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
    end

    assign next_state = (last_round ? sr : mc) ^ round_key;

endmodule

// File: rtl/aes_sbox.sv
// aes_sbox: one combinational AES S-box lane.
//   din  : input byte
//   dout : substituted byte
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = sbox(din);

endmodule

// File: rtl/aes_shift_rows.sv
// aes_shift_rows: ShiftRows permutation. Byte k of the state sits at
// [127-8k -: 8] with k = 4*column + row; row r rotates left by r columns.
//   din  : state in
//   dout : shifted state
module aes_shift_rows
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] din,
    output logic [AES_BLK_W-1:0] dout
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign dout[127-8*(r+4*c) -: 8] = din[127-8*(r+4*((c+r)%4)) -: 8];
        end
    end

endmodule

// File: rtl/aes_subbytes.sv
// aes_subbytes: 16-lane SubBytes over a full 128-bit state.
//   din  : state in
//   dout : state with every byte substituted
module aes_subbytes
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] din,
    output logic [AES_BLK_W-1:0] dout
);

    for (genvar g = 0; g < 16; g++) begin : g_lane
        aes_sbox u_sbox (
            .din  (din[8*g +: 8]),
            .dout (dout[8*g +: 8])
        );
    end

endmodule

// File: rtl/aes_enc_iter.sv
// aes_enc_iter: iterative AES-128 encryption, one round per clock, with the
// key schedule computed on the fly.
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   : plaintext + key handshake (in_ready only in IDLE)
//   in_data, in_key     : plaintext and key, [127:120] = byte 0
//   out_valid/out_ready : ciphertext handshake, out_data held while stalled
//   out_data            : ciphertext, keeps the last result after transfer
//   busy                : high in RUN or DONE
// Optional (macro AES_ROUND_TRACE_EN):
//   trace_valid         : high exactly while in RUN
//   trace_state         : state register, including round-0 AddRoundKey
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// RUN   | one AES round per edge, rnd = 1..NUM_ROUNDS
// DONE  | ciphertext presented, waiting for out_ready
module aes_enc_iter
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int DATA_W     = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
`ifdef AES_ROUND_TRACE_EN
    ,
    output logic              trace_valid,
    output logic [DATA_W-1:0] trace_state
`endif
);

    if (DATA_W != AES_BLK_W) begin : g_bad_width
        $fatal(1, "aes_enc_iter: DATA_W must be 128");
    end
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 10) begin : g_bad_rounds
        $fatal(1, "aes_enc_iter: NUM_ROUNDS must be in 1..10");
    end

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    state_t            fsm;
    logic [3:0]        rnd;
    logic [DATA_W-1:0] state_q;
    logic [DATA_W-1:0] rkey_q;
    logic [DATA_W-1:0] rkey_next;
    logic [DATA_W-1:0] round_out;
    logic              last_round;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w3, sub_w3, t_word;
    logic [31:0] n0, n1, n2, n3;

    // On-the-fly key schedule: next round key from the current one.
    assign {w0, w1, w2, w3} = rkey_q;
    assign rot_w3 = {w3[23:0], w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_ks_sbox
        aes_sbox u_ks_sbox (
            .din  (rot_w3[8*g +: 8]),
            .dout (sub_w3[8*g +: 8])
        );
    end

    assign t_word    = sub_w3 ^ {rcon(rnd), 24'h0};
    assign n0        = w0 ^ t_word;
    assign n1        = w1 ^ n0;
    assign n2        = w2 ^ n1;
    assign n3        = w3 ^ n2;
    assign rkey_next = {n0, n1, n2, n3};

    assign last_round = (rnd == LAST_RND);

    aes_round_comb u_round (
        .state      (state_q),
        .round_key  (rkey_next),
        .last_round (last_round),
        .next_state (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            rnd       <= 4'd0;
            state_q   <= '0;
            rkey_q    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        state_q  <= in_data ^ in_key;
                        rkey_q   <= in_key;
                        rnd      <= 4'd1;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        fsm      <= RUN;
                    end
                end
                RUN: begin
                    rkey_q <= rkey_next;
                    rnd    <= rnd + 4'd1;
                    if (last_round) begin
                        out_data  <= round_out;
                        out_valid <= 1'b1;
                        fsm       <= DONE;
                    end else begin
                        state_q <= round_out;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        fsm       <= IDLE;
                    end
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

`ifdef AES_ROUND_TRACE_EN
    // Tracks "FSM will be in RUN next cycle" so it lines up with fsm == RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            trace_valid <= 1'b0;
        end else if (fsm == IDLE) begin
            trace_valid <= in_valid && in_ready;
        end else if (fsm == RUN) begin
            trace_valid <= !last_round;
        end else begin
            trace_valid <= 1'b0;
        end
    end

    assign trace_state = state_q;
`endif

endmodule

// File: tb/tb_aes_enc_iter.sv
module tb_aes_enc_iter;

    localparam int NR = 10;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
`ifdef AES_ROUND_TRACE_EN
    logic         trace_valid;
    logic [127:0] trace_state;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0] sbox_tab [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_enc_iter #(
        .NUM_ROUNDS (NR),
        .DATA_W     (128)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef AES_ROUND_TRACE_EN
        ,
        .trace_valid (trace_valid),
        .trace_state (trace_state)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] v;
        v = b;
        for (int i = 0; i < n; i++) v = {v[6:0], v[7]};
        return v;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] key, input int nr);
        logic [7:0]   st [16];
        logic [7:0]   rk [16];
        logic [7:0]   tmp [16];
        logic [7:0]   t [4];
        logic [7:0]   coef [4];
        logic [7:0]   rc;
        logic [7:0]   acc;
        logic [127:0] res;
        coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int i = 0; i < 16; i++) begin
            rk[i] = key[127-8*i -: 8];
            st[i] = pt[127-8*i -: 8] ^ rk[i];
        end
        rc = 8'h01;
        for (int r = 1; r <= nr; r++) begin
            t[0] = sbox_tab[rk[13]] ^ rc;
            t[1] = sbox_tab[rk[14]];
            t[2] = sbox_tab[rk[15]];
            t[3] = sbox_tab[rk[12]];
            for (int i = 0; i < 16; i++) begin
                if (i < 4) rk[i] = rk[i] ^ t[i];
                else       rk[i] = rk[i] ^ rk[i-4];
            end
            rc = gmul(rc, 8'h02);
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    tmp[row+4*c] = sbox_tab[st[row + 4*((c+row)%4)]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) begin
                    if (r < nr) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++)
                            acc = acc ^ gmul(coef[(j-row+4)%4], tmp[j+4*c]);
                        st[row+4*c] = acc;
                    end else begin
                        st[row+4*c] = tmp[row+4*c];
                    end
                end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a block and returns one cycle after the handshake edge.
    task automatic offer(input logic [127:0] pt, input logic [127:0] key);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = pt;
        in_key   = key;
        while (!in_ready && guard < 40) begin
            step();
            guard++;
        end
        check("handshake_wait", 128'(in_ready), 128'd1);
        step();
    endtask

    // Cycles since the handshake when out_valid is first seen (1 = next cycle).
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            step();
            lat++;
        end
        check("out_valid_wait", 128'(out_valid), 128'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        int           t1;
        logic [127:0] pt, key, exp, held;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        out_ready = 1'b0;
        build_sbox();

        repeat (3) step();
        check("rst_in_ready",  128'(in_ready),  128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data",  out_data,        128'd0);
        check("rst_busy",      128'(busy),      128'd0);
        rst = 1'b0;
        step();
        check("in_ready_after_rst", 128'(in_ready), 128'd1);

        // FIPS-197 App. B with latency
        offer(PT_B, KEY_B);
        in_valid = 1'b0;
        check("busy_run",     128'(busy),     128'd1);
        check("in_ready_run", 128'(in_ready), 128'd0);
        wait_out(lat);
        check("latency_appb", 128'(lat), 128'(NR + 1));
        check("ct_appb",      out_data,  CT_B);
        drain();
        check("out_valid_after_xfer", 128'(out_valid), 128'd0);
        check("in_ready_after_xfer",  128'(in_ready),  128'd1);
        check("out_data_kept",        out_data,        CT_B);

        // C.1 back-to-back, second block offered (and changing) while busy
        pt  = rand128();
        key = rand128();
        out_ready = 1'b1;
        offer(PT_C, KEY_C);
        in_data = pt;
        in_key  = key;
        wait_out(lat);
        t1 = cyc;
        check("ct_c1", out_data, CT_C);
        step();
        wait_out(lat);
        in_valid = 1'b0;
        check("b2b_spacing", 128'(cyc - t1), 128'(NR + 2));
        check("ct_second",   out_data,       aes_model(pt, key, NR));
        step();
        out_ready = 1'b0;

        // Backpressure
        pt  = rand128();
        key = rand128();
        exp = aes_model(pt, key, NR);
        offer(pt, key);
        in_valid = 1'b0;
        wait_out(lat);
        check("ct_bp", out_data, exp);
        held = out_data;
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_out_data",  out_data,        held);
            check("bp_in_ready",  128'(in_ready),  128'd0);
        end
        drain();
        check("bp_released_valid", 128'(out_valid), 128'd0);
        check("bp_released_ready", 128'(in_ready),  128'd1);

        // Reset in round 5
        offer(rand128(), rand128());
        in_valid = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        step();
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_busy",      128'(busy),      128'd0);
        rst = 1'b0;
        step();
        check("midrst_in_ready", 128'(in_ready), 128'd1);
        for (int i = 0; i < 15; i++) begin
            check("midrst_no_output", 128'(out_valid), 128'd0);
            step();
        end
        offer(PT_B, KEY_B);
        in_valid = 1'b0;
        wait_out(lat);
        check("ct_after_rst", out_data, CT_B);
        drain();

        // Randomised blocks with random gaps and stalls
        for (int k = 0; k < 6; k++) begin
            pt  = rand128();
            key = rand128();
            repeat ($urandom_range(0, 3)) step();
            offer(pt, key);
            in_valid = 1'b0;
            wait_out(lat);
            check("rand_latency", 128'(lat), 128'(NR + 1));
            check("rand_ct",      out_data,  aes_model(pt, key, NR));
            repeat ($urandom_range(0, 4)) step();
            drain();
        end

`ifdef AES_ROUND_TRACE_EN
        offer(PT_B, KEY_B);
        in_valid = 1'b0;
        check("trace_valid_run", 128'(trace_valid), 128'd1);
        check("trace_round0",    trace_state, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        step();
        check("trace_round1",    trace_state, 128'ha49c7ff2689f352b6b5bea43026a5049);
        wait_out(lat);
        check("trace_valid_done", 128'(trace_valid), 128'd0);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
